// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg
// Shared helpers for the asynchronous FIFO pointer controllers.
//   bin2gray / gray2bin : width-agnostic code converters. Each takes a value
//                         zero-extended to GRAY_MAX_W bits plus its real width.
//                         Bits above the given width are returned as zero.
//   FULL_MSB_INV        : mask applied to the two MSBs of the synchronized read
//                         pointer before comparing it with the write pointer
//                         for the full test.
package async_fifo_pkg;

    localparam int GRAY_MAX_W = 32;

    // In Gray code, a write pointer exactly one lap ahead of the read pointer
    // differs from it only in the two top bits.
    localparam logic [1:0] FULL_MSB_INV = 2'b11;

    function automatic logic [GRAY_MAX_W-1:0] width_mask(input int width);
        logic [GRAY_MAX_W-1:0] m;
        if (width >= GRAY_MAX_W) m = '1;
        else                     m = (GRAY_MAX_W'(1) << width) - GRAY_MAX_W'(1);
        return m;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(
        input logic [GRAY_MAX_W-1:0] bin,
        input int                    width
    );
        logic [GRAY_MAX_W-1:0] b;
        b = bin & width_mask(width);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of its own Gray bit and all Gray bits above it.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(
        input logic [GRAY_MAX_W-1:0] gray,
        input int                    width
    );
        logic [GRAY_MAX_W-1:0] g;
        logic [GRAY_MAX_W-1:0] b;
        g = gray & width_mask(width);
        b = g;
        for (int i = 1; i < GRAY_MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_ctrl_gray2bin_conv.sv
// gray2bin_conv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Ports:
//   i_gray [W-1:0] : Gray-coded input
//   o_bin  [W-1:0] : binary equivalent
module gray2bin_conv
    import async_fifo_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    assign o_bin = W'(gray2bin(GRAY_MAX_W'(i_gray), W));

endmodule

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl
// Write-side pointer and full-flag controller of the asynchronous FIFO. It owns
// the binary/Gray write pointer and derives full, almost-full, fill level,
// accepted-write count and overflow against the read pointer that has already
// been synchronized into wclk.
// Ports:
//   wclk, hw_rst_n  : write clock, asynchronous active-low reset
//   sw_rst          : synchronous soft reset (honored for SOFT_RESET = 2 or 3)
//   winc            : write request
//   wq2_rptr        : synchronized read pointer, Gray, ADDRESS_WIDTH+1 bits
//   afull_val       : almost-full margin in entries
//   wen, waddr      : memory write enable (combinational) and write address
//   wptr            : Gray write pointer toward the read-domain synchronizer
//   wrfull          : FIFO full
//   wr_almost_full  : fill level >= DEPTH - afull_val
//   wr_level        : fill level 0..DEPTH
//   wr_count        : accepted writes, wraps modulo 2**(ADDRESS_WIDTH+1)
//   wr_overflow     : write attempted while full (pulse, or sticky)
module wptr_full_ctrl
    import async_fifo_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DEPTH         = 16,
    parameter int SOFT_RESET    = 0,
    parameter int STICKY_ERROR  = 0
) (
    input  logic                     wclk,
    input  logic                     hw_rst_n,
    input  logic                     sw_rst,
    input  logic                     winc,
    input  logic [ADDRESS_WIDTH:0]   wq2_rptr,
    input  logic [ADDRESS_WIDTH-1:0] afull_val,
    output logic                     wen,
    output logic [ADDRESS_WIDTH-1:0] waddr,
    output logic [ADDRESS_WIDTH:0]   wptr,
    output logic                     wrfull,
    output logic                     wr_almost_full,
    output logic [ADDRESS_WIDTH:0]   wr_level,
    output logic [ADDRESS_WIDTH:0]   wr_count,
    output logic                     wr_overflow
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int PW = ADDRESS_WIDTH + 1;

    localparam bit SW_RST_EN = (SOFT_RESET == 2) || (SOFT_RESET == 3);
    localparam bit STICKY    = (STICKY_ERROR == 1);

    logic [AW:0] r_wbin;
    logic [AW:0] r_wptr;
    logic [AW:0] r_wr_count;
    logic [AW:0] r_wr_level;
    logic        r_wrfull;
    logic        r_wr_almost_full;
    logic        r_wr_overflow;

    logic        w_accept;
    logic        w_sw_clr;
    logic        w_ovf_evt;
    logic [AW:0] w_wbin_nxt;
    logic [AW:0] w_wgray_nxt;
    logic [AW:0] w_rptr_full_cmp;
    logic        w_full_val;
    logic [AW:0] w_rbin_s;
    logic [AW:0] w_level_nxt;
    logic [AW+1:0] w_afull_thr;
    logic        w_afull_nxt;

    assign w_accept  = winc & ~r_wrfull;
    assign w_sw_clr  = sw_rst & SW_RST_EN;
    assign w_ovf_evt = winc & r_wrfull;

    assign w_wbin_nxt  = r_wbin + {{AW{1'b0}}, w_accept};
    assign w_wgray_nxt = PW'(bin2gray(GRAY_MAX_W'(w_wbin_nxt), PW));

    assign w_rptr_full_cmp = {wq2_rptr[AW:AW-1] ^ FULL_MSB_INV, wq2_rptr[AW-2:0]};
    assign w_full_val      = (w_wgray_nxt == w_rptr_full_cmp);

    gray2bin_conv #(
        .W (PW)
    ) u_rptr_conv (
        .i_gray (wq2_rptr),
        .o_bin  (w_rbin_s)
    );

    // Unsigned modular difference is the true fill level because the write
    // pointer never runs more than DEPTH ahead of the read pointer.
    assign w_level_nxt = w_wbin_nxt - w_rbin_s;

    // One extra bit so a zero margin gives a threshold of exactly DEPTH.
    assign w_afull_thr = (AW+2)'(DEPTH) - {2'b00, afull_val};
    assign w_afull_nxt = ({1'b0, w_level_nxt} >= w_afull_thr);

    always_ff @(posedge wclk or negedge hw_rst_n) begin
        if (!hw_rst_n) begin
            r_wbin           <= '0;
            r_wptr           <= '0;
            r_wr_count       <= '0;
            r_wr_level       <= '0;
            r_wrfull         <= 1'b0;
            r_wr_almost_full <= 1'b0;
            r_wr_overflow    <= 1'b0;
        end else if (w_sw_clr) begin
            // A write presented with the soft reset is dropped.
            r_wbin           <= '0;
            r_wptr           <= '0;
            r_wr_count       <= '0;
            r_wr_level       <= '0;
            r_wrfull         <= 1'b0;
            r_wr_almost_full <= 1'b0;
            r_wr_overflow    <= STICKY ? r_wr_overflow : 1'b0;
        end else begin
            r_wbin           <= w_wbin_nxt;
            r_wptr           <= w_wgray_nxt;
            r_wr_count       <= r_wr_count + {{AW{1'b0}}, w_accept};
            r_wr_level       <= w_level_nxt;
            r_wrfull         <= w_full_val;
            r_wr_almost_full <= w_afull_nxt;
            r_wr_overflow    <= STICKY ? (r_wr_overflow | w_ovf_evt) : w_ovf_evt;
        end
    end

    assign wen            = w_accept;
    assign waddr          = r_wbin[AW-1:0];
    assign wptr           = r_wptr;
    assign wrfull         = r_wrfull;
    assign wr_almost_full = r_wr_almost_full;
    assign wr_level       = r_wr_level;
    assign wr_count       = r_wr_count;
    assign wr_overflow    = r_wr_overflow;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Testbench for wptr_full_ctrl. Two instances share the clock and resets:
//   instance 0: SOFT_RESET=2, STICKY_ERROR=0
//   instance 1: SOFT_RESET=1, STICKY_ERROR=1
// A model tracks each FIFO as integer write/read positions and occupancy.
module tb_wptr_full_ctrl;

    localparam int AW    = 4;
    localparam int PW    = 5;
    localparam int DEPTH = 16;
    localparam int NI    = 2;
    localparam int MODP  = 32;

    logic wclk = 1'b0;
    always #5 wclk = ~wclk;

    logic          hw_rst_n;
    logic          sw_rst;
    logic          winc     [NI];
    logic [PW-1:0] rptr_g   [NI];
    logic [AW-1:0] afull    [NI];

    logic          d_wen    [NI];
    logic [AW-1:0] d_waddr  [NI];
    logic [PW-1:0] d_wptr   [NI];
    logic          d_full   [NI];
    logic          d_afull  [NI];
    logic [PW-1:0] d_level  [NI];
    logic [PW-1:0] d_count  [NI];
    logic          d_ovf    [NI];

    wptr_full_ctrl #(
        .ADDRESS_WIDTH (AW), .DEPTH (DEPTH), .SOFT_RESET (2), .STICKY_ERROR (0)
    ) dut_a (
        .wclk (wclk), .hw_rst_n (hw_rst_n), .sw_rst (sw_rst), .winc (winc[0]),
        .wq2_rptr (rptr_g[0]), .afull_val (afull[0]), .wen (d_wen[0]),
        .waddr (d_waddr[0]), .wptr (d_wptr[0]), .wrfull (d_full[0]),
        .wr_almost_full (d_afull[0]), .wr_level (d_level[0]),
        .wr_count (d_count[0]), .wr_overflow (d_ovf[0])
    );

    wptr_full_ctrl #(
        .ADDRESS_WIDTH (AW), .DEPTH (DEPTH), .SOFT_RESET (1), .STICKY_ERROR (1)
    ) dut_b (
        .wclk (wclk), .hw_rst_n (hw_rst_n), .sw_rst (sw_rst), .winc (winc[1]),
        .wq2_rptr (rptr_g[1]), .afull_val (afull[1]), .wen (d_wen[1]),
        .waddr (d_waddr[1]), .wptr (d_wptr[1]), .wrfull (d_full[1]),
        .wr_almost_full (d_afull[1]), .wr_level (d_level[1]),
        .wr_count (d_count[1]), .wr_overflow (d_ovf[1])
    );

    // Model state
    int m_wpos [NI];
    int m_cnt  [NI];
    int m_lvl  [NI];
    int rpos   [NI];
    bit m_full [NI];
    bit m_afull[NI];
    bit m_ovf  [NI];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic bit honors_sw(input int i);
        return (i == 0);
    endfunction

    function automatic bit is_sticky(input int i);
        return (i == 1);
    endfunction

    task automatic chk(input string name, input int i, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", name, i, act, exp, $time);
        end
    endtask

    task automatic set_rpos(input int i, input int v);
        rpos[i]   = v % MODP;
        rptr_g[i] = PW'(gray(rpos[i]));
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_wpos[i] = 0; m_cnt[i] = 0; m_lvl[i] = 0;
            m_full[i] = 0; m_afull[i] = 0; m_ovf[i] = 0;
            set_rpos(i, 0);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            bit acc;
            bit ev;
            acc = winc[i] && !m_full[i];
            ev  = winc[i] && m_full[i];
            if (sw_rst && honors_sw(i)) begin
                m_wpos[i] = 0; m_cnt[i] = 0; m_lvl[i] = 0;
                m_full[i] = 0; m_afull[i] = 0;
                if (!is_sticky(i)) m_ovf[i] = 0;
            end else begin
                m_ovf[i]   = is_sticky(i) ? (m_ovf[i] || ev) : ev;
                m_wpos[i]  = (m_wpos[i] + int'(acc)) % MODP;
                m_cnt[i]   = (m_cnt[i] + int'(acc)) % MODP;
                m_lvl[i]   = (m_wpos[i] - rpos[i] + MODP) % MODP;
                m_full[i]  = (m_lvl[i] == DEPTH);
                m_afull[i] = (m_lvl[i] >= DEPTH - int'(afull[i]));
            end
        end
    endtask

    task automatic cmp_all();
        for (int i = 0; i < NI; i++) begin
            chk("wptr",        i, int'(d_wptr[i]),  gray(m_wpos[i]));
            chk("waddr",       i, int'(d_waddr[i]), m_wpos[i] % DEPTH);
            chk("wr_count",    i, int'(d_count[i]), m_cnt[i]);
            chk("wr_level",    i, int'(d_level[i]), m_lvl[i]);
            chk("wrfull",      i, int'(d_full[i]),  int'(m_full[i]));
            chk("almost_full", i, int'(d_afull[i]), int'(m_afull[i]));
            chk("wr_overflow", i, int'(d_ovf[i]),   int'(m_ovf[i]));
        end
    endtask

    // Inputs are set at the falling edge before calling; returns at the next falling edge.
    task automatic step();
        #1;
        for (int i = 0; i < NI; i++)
            chk("wen", i, int'(d_wen[i]), int'(winc[i] && !m_full[i]));
        @(posedge wclk);
        model_edge();
        #1;
        cmp_all();
        @(negedge wclk);
    endtask

    task automatic set_winc(input logic v);
        for (int i = 0; i < NI; i++) winc[i] = v;
    endtask

    task automatic hw_reset();
        #2;
        hw_rst_n = 1'b0;
        #1;
        model_reset();
        cmp_all();
        @(negedge wclk);
        hw_rst_n = 1'b1;
    endtask

    initial begin
        hw_rst_n = 1'b0;
        sw_rst   = 1'b0;
        for (int i = 0; i < NI; i++) begin
            winc[i] = 1'b0; afull[i] = '0;
        end
        model_reset();
        repeat (2) @(negedge wclk);
        cmp_all();
        chk("rst_wrfull", 0, int'(d_full[0]), 0);
        chk("rst_wen",    0, int'(d_wen[0]), 0);
        hw_rst_n = 1'b1;
        @(negedge wclk);

        // Fill from empty with the read pointer parked at 0
        set_winc(1'b1);
        for (int k = 0; k < DEPTH; k++) begin
            chk("fill_waddr", 0, int'(d_waddr[0]), k);
            step();
            if (k == DEPTH - 2) chk("fill_not_full_15", 0, int'(d_full[0]), 0);
        end
        chk("fill_wptr",  0, int'(d_wptr[0]),  5'b11000);
        chk("fill_level", 0, int'(d_level[0]), 16);
        chk("fill_count", 0, int'(d_count[0]), 16);
        chk("fill_full",  0, int'(d_full[0]),  1);

        // Two rejected writes while full
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("ovf_wen", 0, int'(d_wen[0]), 0);
            step();
            chk("ovf_wptr",  0, int'(d_wptr[0]), 5'b11000);
            chk("ovf_pulse", 0, int'(d_ovf[0]),  1);
        end
        set_winc(1'b0);
        step();
        chk("ovf_nonsticky_drop", 0, int'(d_ovf[0]), 0);
        chk("ovf_sticky_hold",    1, int'(d_ovf[1]), 1);

        // Reader frees one slot
        set_rpos(0, 1);
        set_rpos(1, 1);
        step();
        chk("drain_full",  0, int'(d_full[0]),  0);
        chk("drain_level", 0, int'(d_level[0]), 15);
        set_winc(1'b1);
        #1;
        chk("drain_waddr", 0, int'(d_waddr[0]), 0);
        chk("drain_wen",   0, int'(d_wen[0]),   1);
        step();
        chk("drain_refull", 0, int'(d_full[0]), 1);

        // Hardware reset in the middle of a burst
        step();
        hw_reset();
        chk("hwrst_sticky_clr", 1, int'(d_ovf[1]), 0);
        chk("hwrst_wptr",       0, int'(d_wptr[0]), 0);
        for (int i = 0; i < NI; i++) afull[i] = 4'd2;
        set_winc(1'b1);
        #1;
        chk("post_rst_waddr", 0, int'(d_waddr[0]), 0);
        chk("post_rst_wen",   0, int'(d_wen[0]),   1);
        step();
        chk("post_rst_waddr_adv", 0, int'(d_waddr[0]), 1);

        // Almost full with a margin of 2
        for (int k = 1; k < 13; k++) step();
        chk("afull_13", 0, int'(d_afull[0]), 0);
        step();
        chk("afull_14",      0, int'(d_afull[0]), 1);
        chk("afull_14_full", 0, int'(d_full[0]),  0);
        step();
        step();
        chk("afull_16_full", 0, int'(d_full[0]), 1);
        set_winc(1'b0);

        // Soft reset with a simultaneous write
        hw_reset();
        set_winc(1'b1);
        repeat (5) step();
        sw_rst = 1'b1;
        step();
        sw_rst = 1'b0;
        set_winc(1'b0);
        chk("swrst_wptr",   0, int'(d_wptr[0]),  0);
        chk("swrst_count",  0, int'(d_count[0]), 0);
        chk("swign_count",  1, int'(d_count[1]), 6);
        chk("swign_wptr",   1, int'(d_wptr[1]),  5);

        // Randomized traffic with phases of slow and fast reading
        hw_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NI; i++) begin
                int adv;
                int occ;
                winc[i] = ($urandom_range(0, 9) < 7);
                if (((n / 300) % 2) == 0) adv = ($urandom_range(0, 3) == 0) ? 1 : 0;
                else                      adv = $urandom_range(0, 2);
                occ = (m_wpos[i] - rpos[i] + MODP) % MODP;
                if (adv > occ) adv = occ;
                set_rpos(i, rpos[i] + adv);
                if ($urandom_range(0, 15) == 0) afull[i] = AW'($urandom_range(0, 15));
            end
            sw_rst = ($urandom_range(0, 63) == 0);
            if (sw_rst) set_rpos(0, 0);
            step();
            sw_rst = 1'b0;
            if (n == 1500) hw_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
